fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage: owns the PC, issues word fetches to instruction memory over a req/ready handshake, and loads the IF/ID register that feeds the decoder. It consumes the decoder's `pc_src`/target redirect and the hazard stall, and buffers one in-flight word when decode is stalled. It detects the halt opcode and freezes fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `NOP_INST`, default 32'h0000_0013: word placed in IF/ID on flush/reset (addi x0,x0,0).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc_src`  in  2  decoder PC select: 00 = PC+4, 01 = redirect to `target`, 10 = hold (bubble), 11 = treated as 00.
- `target`  in  32  redirect address, valid when `pc_src`==01.
- `stall`  in  1  hazard stall: IF/ID must hold.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (= PC register).
- `imem_ready`  in  1  response valid / request accepted this cycle.
- `imem_rdata`  in  32  fetched word, valid with `imem_ready`.
- `inst`  out  32  IF/ID instruction.
- `inst_pc`  out  32  IF/ID PC.
- `inst_valid`  out  1  IF/ID holds a real (non-flushed) instruction.
- `halted`  out  1  halt opcode reached IF/ID.

## Operation
- Reset values: `pc`=RESET_PC, `imem_req`=0, `inst`=NOP_INST, `inst_pc`=0, `inst_valid`=0, `halted`=0, hold buffer empty, state IDLE.
- The effective stall is `stall | (pc_src==10)`. The effective redirect is `pc_src==01`.
- States:
  - IDLE: `imem_req`=0. Goes to FETCH next cycle.
  - FETCH: `imem_req` = !hold_valid.
  - DRAIN: `imem_req`=1 at the old address. The response is discarded.
  - HALT: `imem_req`=0. Exits only via reset.
- Handshake: `imem_addr` is stable while `imem_req`=1 && !`imem_ready`. A transfer completes on `imem_req` && `imem_ready`.
- Transfer completes in FETCH, priority order:
  1. Redirect: discard the word, `pc`<=`target`, IF/ID<=NOP with `inst_valid`=0, hold cleared.
  2. Stall: word and PC go to the hold buffer, `pc`<=`pc`+4, IF/ID unchanged.
  3. Else: IF/ID<={word, pc}, `inst_valid`=1, `pc`<=`pc`+4.
- Redirect in FETCH with a request outstanding and not completing: go to DRAIN, latch `target` into `redir_pc`, IF/ID<=NOP/invalid, clear hold.
- Redirect in FETCH with no request (hold_valid=1): clear hold, `pc`<=`target`, IF/ID<=NOP/invalid.
- DRAIN:
  - A further redirect overwrites `redir_pc` (latest wins).
  - On completion: discard the word, `pc`<=`redir_pc`, go to FETCH.
  - `stall` is ignored.
- Hold buffer release: in FETCH with no stall, no redirect and hold_valid=1, IF/ID<=hold contents, hold_valid<=0.
- IF/ID during stall: when the effective stall is high and there is no redirect, IF/ID holds its value.
- Halt: when a word with opcode [6:0]==7'b1111111 is written into IF/ID (from memory or from hold), go to HALT and set `halted`=1.
  - IF/ID keeps the halt word with `inst_valid`=1.
  - `pc` is not advanced further, and `pc_src` and `stall` are ignored.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. `target` is used as given; no alignment check.
- `rst_n` asserted mid-transfer returns every output to its reset value immediately. Any outstanding memory response is not tracked.

## Timing
- Zero-wait memory (`imem_ready`=1 with req): one instruction per cycle. Word appears on `inst` in the cycle after the transfer.
- First `imem_req` is asserted in the 2nd cycle after `rst_n` deasserts (one IDLE cycle).
- Redirect to first target-path `inst_valid`:
  - 2 cycles with zero-wait memory.
  - DRAIN adds the remaining wait cycles of the dropped transfer.
- Stall release with hold_valid=1: IF/ID updates in that cycle. `imem_req` reasserts the following cycle.
- `halted` rises in the same cycle the halt word appears on `inst`.

## Structure
- Shared package contents:
  - `pc_src` encodings: PC_PLUS4=2'b00, PC_TARGET=2'b01, PC_HOLD=2'b10.
  - OPC_HALT=7'b1111111.
  - NOP_INST default.
  - Fetch state enum: IDLE/FETCH/DRAIN/HALT.
- One sub-module, `fetch_skid_buffer`: a 1-entry {inst, pc} buffer with load/release/clear and `hold_valid`.

## Test plan
- Reset release, zero-wait memory returning addr-indexed words → `imem_addr` 0,4,8 on consecutive cycles starting cycle 2; `inst_pc` 0,4,8 with `inst_valid`=1.
- Memory with 3 wait cycles → `imem_addr` held at 0x4 for 4 cycles; `inst` updates once per transfer.
- `stall`=1 for 3 cycles while word @0x8 returns → IF/ID holds @0x4; `imem_req`=0 during stall. After release, IF/ID=@0x8, then fetch resumes at 0xC.
- `pc_src`=01, `target`=0x100 during a 2-wait-cycle fetch of 0x10 → DRAIN; the 0x10 word is never valid in IF/ID; next `imem_addr`=0x100; `inst_valid`=0 until @0x100 arrives.
- Word 0x0000007F fetched at 0x20 → `halted`=1, `inst`=0x7F, `imem_req` stays 0; a later `pc_src`=01 is ignored.
- `rst_n` low mid-DRAIN → all outputs return to reset values immediately; after release, first `imem_addr`=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction fetch stage.
package fetch_unit_pkg;

    // Decoder PC select encodings; 2'b11 behaves like PC_PLUS4.
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_HOLD   = 2'b10;

    localparam logic [6:0]  OPC_HALT         = 7'b1111111;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc} buffer catching a word that returns while decode is stalled.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        hold_valid,
    output logic [31:0] hold_inst,
    output logic [31:0] hold_pc
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    // Clear beats load beats pop; data is only captured on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            inst_q  <= in_inst;
            pc_q    <= in_pc;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign hold_valid = valid_q;
    assign hold_inst  = inst_q;
    assign hold_pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, IF/ID register, redirect drain and halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          pc_src,
    input  logic [31:0]         target,
    input  logic                stall,
    fetch_unit_if.master        imem,
    output logic [31:0]         inst,
    output logic [31:0]         inst_pc,
    output logic                inst_valid,
    output logic                halted
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  redir_pc_q;
    logic [31:0]  inst_q;
    logic [31:0]  inst_pc_q;
    logic         inst_valid_q;
    logic         halted_q;

    logic         hold_valid;
    logic [31:0]  hold_inst;
    logic [31:0]  hold_pc;

    logic         redirect;
    logic         eff_stall;
    logic         req;
    logic         xfer;
    logic         in_fetch;
    logic         wr_en;
    logic [31:0]  wr_inst;
    logic [31:0]  wr_pc;

    // Request, transfer and IF/ID write-source decode.
    always_comb begin
        redirect  = (pc_src == PC_TARGET);
        eff_stall = stall | (pc_src == PC_HOLD);
        in_fetch  = (state_q == StFetch);
        req       = (in_fetch && !hold_valid) || (state_q == StDrain);
        xfer      = req & imem.ready;
        wr_en     = 1'b0;
        wr_inst   = hold_inst;
        wr_pc     = hold_pc;
        if (in_fetch && !redirect && !eff_stall) begin
            if (hold_valid) begin
                wr_en = 1'b1;
            end else if (xfer) begin
                wr_en   = 1'b1;
                wr_inst = imem.rdata;
                wr_pc   = pc_q;
            end
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (in_fetch && !redirect && eff_stall && xfer),
        .pop        (in_fetch && !redirect && !eff_stall && hold_valid),
        .clear      (in_fetch && redirect),
        .in_inst    (imem.rdata),
        .in_pc      (pc_q),
        .hold_valid (hold_valid),
        .hold_inst  (hold_inst),
        .hold_pc    (hold_pc)
    );

    // Fetch FSM with PC, redirect latch and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (redirect) begin
                        inst_q       <= NOP_INST;
                        inst_valid_q <= 1'b0;
                        if (req && !imem.ready) begin
                            state_q    <= StDrain;
                            redir_pc_q <= target;
                        end else begin
                            pc_q <= target;
                        end
                    end else begin
                        if (xfer) pc_q <= pc_q + 32'd4;
                        if (wr_en) begin
                            inst_q       <= wr_inst;
                            inst_pc_q    <= wr_pc;
                            inst_valid_q <= 1'b1;
                            if (wr_inst[6:0] == OPC_HALT) begin
                                state_q  <= StHalt;
                                halted_q <= 1'b1;
                            end
                        end else if (!eff_stall) begin
                            // Nothing arrived: present a bubble rather than repeat the word.
                            inst_valid_q <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    if (redirect) redir_pc_q <= target;
                    if (xfer) begin
                        pc_q    <= redirect ? target : redir_pc_q;
                        state_q <= StFetch;
                    end
                end
                StHalt: ;
            endcase
        end
    end

    assign imem.req   = req;
    assign imem.addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, hand sequences and a randomized model comparison.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] target = '0;
    logic        stall = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        halted;
    logic [31:0] halt_addr = 32'hFFFF_FF00;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_src     (pc_src),
        .target     (target),
        .stall      (stall),
        .imem       (bus),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Memory returns a word derived from the requested address; one address holds the halt word.
    assign bus.rdata = (bus.addr == halt_addr) ? 32'h0000_007F : {bus.addr[24:0], 7'h13};

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == halt_addr) ? 32'h0000_007F : {a[24:0], 7'h13};
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int ModeIdle = 0, ModeFetch = 1, ModeDrain = 2, ModeHalt = 3;
    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    int          m_mode;
    logic [31:0] m_pc, m_redir, m_inst, m_ipc;
    logic        m_valid, m_halted;
    ent_t        m_hold[$];

    task automatic model_reset();
        m_mode = ModeIdle; m_pc = 32'h0; m_redir = 32'h0;
        m_inst = NOP; m_ipc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
        m_hold.delete();
    endtask

    function automatic logic model_req();
        return (m_mode == ModeFetch && m_hold.size() == 0) || m_mode == ModeDrain;
    endfunction

    task automatic retire(input logic [31:0] w, input logic [31:0] a);
        m_inst = w; m_ipc = a; m_valid = 1'b1;
        if (w[6:0] == 7'h7F) begin
            m_mode = ModeHalt;
            m_halted = 1'b1;
        end
    endtask

    task automatic model_step(input logic st, input logic [1:0] src, input logic [31:0] tgt,
                              input logic rdy);
        logic redir, est, rq, done;
        logic [31:0] w;
        ent_t e;
        redir = (src == 2'b01);
        est   = st || (src == 2'b10);
        rq    = model_req();
        done  = rq && rdy;
        w     = word_at(m_pc);
        case (m_mode)
            ModeIdle: m_mode = ModeFetch;
            ModeFetch: begin
                if (redir) begin
                    m_hold.delete();
                    m_inst = NOP; m_valid = 1'b0;
                    if (rq && !rdy) begin
                        m_mode = ModeDrain; m_redir = tgt;
                    end else begin
                        m_pc = tgt;
                    end
                end else if (est) begin
                    if (done) begin
                        e.w = w; e.a = m_pc;
                        m_hold.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                end else if (m_hold.size() > 0) begin
                    e = m_hold.pop_front();
                    retire(e.w, e.a);
                end else if (done) begin
                    retire(w, m_pc);
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_valid = 1'b0;
                end
            end
            ModeDrain: begin
                if (redir) m_redir = tgt;
                if (done) begin
                    m_pc = m_redir; m_mode = ModeFetch;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".req"}, {31'b0, bus.req}, {31'b0, model_req()});
        chk({tag, ".addr"}, bus.addr, m_pc);
        chk({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, m_valid});
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
        if (m_valid) begin
            chk({tag, ".inst"}, inst, m_inst);
            chk({tag, ".inst_pc"}, inst_pc, m_ipc);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Returns at a falling edge with reset just released (first cycle is the idle cycle).
    task automatic do_reset();
        pc_src = 2'b00; target = '0; stall = 1'b0; bus.ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_cycle(input logic st, input logic [1:0] src, input logic [31:0] tgt,
                               input logic rdy);
        stall = st; pc_src = src; target = tgt; bus.ready = rdy;
        @(negedge clk);
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  src;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_ipc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Each row: inputs for this cycle and the outputs visible during it.
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};  // idle cycle
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 2'b00, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};  // @8 goes to hold
        vecs[4]  = '{1'b1, 2'b00, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h4};
        vecs[5]  = '{1'b0, 2'b10, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h4};  // pc_src hold = stall
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h4};  // release hold
        vecs[7]  = '{1'b0, 2'b11, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h8};  // 11 acts as +4
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC};  // 3 wait cycles
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
        vecs[13] = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14};

        // ---- directed table ----
        halt_addr = 32'hFFFF_FF00;
        do_reset();
        chk("reset.inst", inst, NOP);
        chk("reset.inst_pc", inst_pc, 32'h0);
        for (int i = 0; i < 14; i++) begin
            stall = vecs[i].st; pc_src = vecs[i].src; target = 32'h0; bus.ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d.req", i), {31'b0, bus.req}, {31'b0, vecs[i].exp_req});
            chk($sformatf("vec%0d.addr", i), bus.addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d.valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d.inst_pc", i), inst_pc, vecs[i].exp_ipc);
                chk($sformatf("vec%0d.inst", i), inst, word_at(vecs[i].exp_ipc));
            end
            @(negedge clk);
        end

        // ---- redirect during an outstanding fetch drains it ----
        do_reset();
        repeat (5) drive_cycle(1'b0, 2'b00, 32'h0, 1'b1);
        chk("redir.pre_addr", bus.addr, 32'h10);
        drive_cycle(1'b0, 2'b01, 32'h100, 1'b0);
        chk("redir.drain_req", {31'b0, bus.req}, 32'd1);
        chk("redir.drain_addr", bus.addr, 32'h10);
        chk("redir.drain_valid", {31'b0, inst_valid}, 32'd0);
        chk("redir.drain_nop", inst, NOP);
        drive_cycle(1'b1, 2'b00, 32'h0, 1'b0);  // stall ignored while draining
        chk("redir.drain_hold_addr", bus.addr, 32'h10);
        drive_cycle(1'b0, 2'b00, 32'h0, 1'b1);
        chk("redir.target_addr", bus.addr, 32'h100);
        chk("redir.target_invalid", {31'b0, inst_valid}, 32'd0);
        drive_cycle(1'b0, 2'b00, 32'h0, 1'b1);
        chk("redir.first_valid", {31'b0, inst_valid}, 32'd1);
        chk("redir.first_pc", inst_pc, 32'h100);
        chk("redir.first_inst", inst, word_at(32'h100));
        // Zero-wait redirect to the top of memory, then wrap to 0.
        drive_cycle(1'b0, 2'b01, 32'hFFFF_FFFC, 1'b1);
        chk("wrap.addr", bus.addr, 32'hFFFF_FFFC);
        drive_cycle(1'b0, 2'b00, 32'h0, 1'b1);
        chk("wrap.next_addr", bus.addr, 32'h0);
        chk("wrap.inst_pc", inst_pc, 32'hFFFF_FFFC);

        // ---- latest redirect wins in drain, then reset mid-drain ----
        do_reset();
        repeat (3) drive_cycle(1'b0, 2'b00, 32'h0, 1'b1);
        drive_cycle(1'b0, 2'b01, 32'h100, 1'b0);
        drive_cycle(1'b0, 2'b01, 32'h200, 1'b0);
        drive_cycle(1'b0, 2'b00, 32'h0, 1'b1);
        chk("latest.addr", bus.addr, 32'h200);
        drive_cycle(1'b0, 2'b01, 32'h40, 1'b0);
        chk("drain2.req", {31'b0, bus.req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.req", {31'b0, bus.req}, 32'd0);
        chk("arst.addr", bus.addr, 32'h0);
        chk("arst.inst", inst, NOP);
        chk("arst.inst_pc", inst_pc, 32'h0);
        chk("arst.valid", {31'b0, inst_valid}, 32'd0);
        chk("arst.halted", {31'b0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready = 1'b1; pc_src = 2'b00;
        #1;
        chk("arst.idle_req", {31'b0, bus.req}, 32'd0);
        @(negedge clk);
        chk("arst.first_req", {31'b0, bus.req}, 32'd1);
        chk("arst.first_addr", bus.addr, 32'h0);

        // ---- halt word freezes fetch ----
        halt_addr = 32'h20;
        do_reset();
        repeat (10) drive_cycle(1'b0, 2'b00, 32'h0, 1'b1);
        chk("halt.halted", {31'b0, halted}, 32'd1);
        chk("halt.inst", inst, 32'h0000_007F);
        chk("halt.inst_pc", inst_pc, 32'h20);
        chk("halt.valid", {31'b0, inst_valid}, 32'd1);
        chk("halt.req", {31'b0, bus.req}, 32'd0);
        repeat (2) drive_cycle(1'b0, 2'b01, 32'h200, 1'b1);
        chk("halt.redir_ignored_req", {31'b0, bus.req}, 32'd0);
        chk("halt.redir_ignored_inst", inst, 32'h0000_007F);
        chk("halt.still_halted", {31'b0, halted}, 32'd1);
        chk("halt.still_valid", {31'b0, inst_valid}, 32'd1);

        // ---- randomized episodes against the reference model ----
        for (int ep = 0; ep < 20; ep++) begin
            halt_addr = 32'($urandom_range(16, 255)) * 32'd4;
            do_reset();
            model_reset();
            for (int c = 0; c < 200; c++) begin
                logic [1:0]  s;
                logic [31:0] t;
                logic        st, rdy;
                case ($urandom_range(0, 9))
                    0:       s = 2'b01;
                    1:       s = 2'b10;
                    2:       s = 2'b11;
                    default: s = 2'b00;
                endcase
                t   = 32'($urandom_range(0, 255)) * 32'd4;
                st  = ($urandom_range(0, 3) == 0);
                rdy = ($urandom_range(0, 2) != 0);
                stall = st; pc_src = s; target = t; bus.ready = rdy;
                #1;
                check_model($sformatf("rnd%0d.%0d", ep, c));
                model_step(st, s, t, rdy);
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
